// File: rtl/bg_pkg.sv
// Shared background-tile definitions: map geometry, attribute word layout and
// the attribute struct used by both the renderer and the game_engine writers.
package bg_pkg;

   localparam int TILE_W       = 16;
   localparam int TILE_SHIFT   = $clog2(TILE_W);
   localparam int TILE_COLS    = 40;
   localparam int TILE_ROWS    = 30;
   localparam int SHEET_ADDR_W = 14;

   localparam int H_ACTIVE = TILE_COLS * TILE_W;
   localparam int V_ACTIVE = TILE_ROWS * TILE_W;

`ifdef BG_HUD_LOCK_EN
   localparam int HUD_LINES = 32;
`endif

   localparam logic [11:0] KEY_COLOR = 12'hF0F;
   localparam logic [11:0] BG_COLOR  = 12'h000;

   // Bit positions inside the 32-bit tile attribute word.
   localparam int ATTR_COL_LSB = 0;
   localparam int ATTR_ROW_LSB = 3;
   localparam int ATTR_XFLIP   = 6;
   localparam int ATTR_YFLIP   = 7;
   localparam int ATTR_ENABLE  = 8;

   typedef struct packed {
      logic [22:0] rsvd;
      logic        en;
      logic        yflip;
      logic        xflip;
      logic [2:0]  row;
      logic [2:0]  col;
   } bg_attr_t;

   // Per-pixel sideband carried alongside the RAM/ROM latency.
   typedef struct packed {
      logic       v;
      logic [3:0] px;
      logic [3:0] py;
   } bg_side_t;

endpackage

// File: rtl/bg_attr_decode.sv
// Combinational tile-attribute unpack: applies the flips to the in-tile pixel
// position and forms the 128x128 sprite-sheet address.
module bg_attr_decode
   import bg_pkg::*;
(
   input  logic [31:0]             attr_i,
   input  logic [3:0]              px_i,
   input  logic [3:0]              py_i,
   output logic [SHEET_ADDR_W-1:0] sheet_addr_o,
   output logic                    en_o
);

   logic [2:0] col;
   logic [2:0] row;
   logic [3:0] px_f;
   logic [3:0] py_f;
   logic       unused_attr_bits;

   always_comb begin
      col  = attr_i[ATTR_COL_LSB +: 3];
      row  = attr_i[ATTR_ROW_LSB +: 3];
      // Within a 4-bit tile coordinate, 15-p is just the bitwise complement.
      px_f = attr_i[ATTR_XFLIP] ? ~px_i : px_i;
      py_f = attr_i[ATTR_YFLIP] ? ~py_i : py_i;
      sheet_addr_o = {row, py_f, col, px_f};
      en_o         = attr_i[ATTR_ENABLE];
   end

   assign unused_attr_bits = ^attr_i[31:ATTR_ENABLE+1];

endmodule

// File: rtl/bg_tile_renderer.sv
// Background tile renderer: scan position -> tile RAM -> sprite sheet -> RGB,
// fixed 4-clock pipeline. Define BG_HUD_LOCK_EN to freeze scroll on HUD lines.
module bg_tile_renderer
   import bg_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    video_on,
   input  logic [9:0]              x,
   input  logic [9:0]              y,
   input  logic [3:0]              bg_x_offset,
   output logic [15:0]             bg_ram_rd_addr,
   input  logic [31:0]             bg_ram_rd_data,
   output logic [SHEET_ADDR_W-1:0] sheet_addr,
   input  logic [11:0]             sheet_data,
   output logic [11:0]             pixel_rgb,
   output logic                    pixel_opaque,
   output logic                    de_out
);

   logic [3:0]              eff_off;
   logic [10:0]             sx_sum;
   logic [10:0]             sx;
   logic [15:0]             addr_d, addr_q;
   bg_side_t                side1_d, side1_q, side2_q;
   logic [SHEET_ADDR_W-1:0] sheet_d, sheet_q;
   logic                    en_d, en3_q, en4_q;
   logic                    v3_q, v4_q;
   logic [11:0]             rgb_d, rgb_q;
   logic                    opaque_d, opaque_q;
   logic                    de_q;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      eff_off = bg_x_offset;
`ifdef BG_HUD_LOCK_EN
      if (y < 10'(HUD_LINES)) eff_off = '0;
`endif
      sx_sum = {1'b0, x} + {7'b0, eff_off};
      sx     = (sx_sum >= 11'(H_ACTIVE)) ? sx_sum - 11'(H_ACTIVE) : sx_sum;
      addr_d = 16'(sx >> TILE_SHIFT) + 16'(y >> TILE_SHIFT) * 16'(TILE_COLS);

      side1_d.v  = video_on & (x < 10'(H_ACTIVE)) & (y < 10'(V_ACTIVE));
      side1_d.px = sx[3:0];
      side1_d.py = y[3:0];
   end

   bg_attr_decode u_decode (
      .attr_i       (bg_ram_rd_data),
      .px_i         (side2_q.px),
      .py_i         (side2_q.py),
      .sheet_addr_o (sheet_d),
      .en_o         (en_d)
   );

   always_comb begin
      opaque_d = v4_q & en4_q & (sheet_data != KEY_COLOR);
      rgb_d    = opaque_d ? sheet_data : (v4_q ? BG_COLOR : 12'h000);
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         side1_q  <= '0;
         side2_q  <= '0;
         sheet_q  <= '0;
         en3_q    <= 1'b0;
         v3_q     <= 1'b0;
         en4_q    <= 1'b0;
         v4_q     <= 1'b0;
         rgb_q    <= '0;
         opaque_q <= 1'b0;
         de_q     <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         side1_q  <= side1_d;
         side2_q  <= side1_q;
         sheet_q  <= sheet_d;
         en3_q    <= en_d;
         v3_q     <= side2_q.v;
         en4_q    <= en3_q;
         v4_q     <= v3_q;
         rgb_q    <= rgb_d;
         opaque_q <= opaque_d;
         de_q     <= v4_q;
      end
   end

   assign bg_ram_rd_addr = addr_q;
   assign sheet_addr     = sheet_q;
   assign pixel_rgb      = rgb_q;
   assign pixel_opaque   = opaque_q;
   assign de_out         = de_q;

endmodule

// File: doc/bg_tile_renderer.md
Name: bg_tile_renderer

Overview:
- Read side of the background tile RAM that game_engine writes: 40x30 map of 16x16 tiles, attribute word per tile.
- Each pixel clock, takes the VGA scan position (x, y) and the fine scroll offset, fetches the tile attribute, and decodes column/row/flip/enable.
- Addresses the 128x128 sprite sheet ROM and emits a registered 12-bit RGB pixel plus opaque and data-enable flags to the pixel mixer.
- Runs at one pixel per clk; fixed 4-clock pipeline.

Parameters:
- TILE_COLS, 40, tiles per map row; map address = col + row*TILE_COLS.
- H_ACTIVE, 640, active width; scrolled x wraps modulo H_ACTIVE.
- V_ACTIVE, 480, active height.
- KEY_COLOR, 12'hF0F, sheet colour treated as transparent.
- BG_COLOR, 12'h000, colour emitted when the pixel is not opaque.
- HUD_LINES, 32, top scanlines unaffected by scroll (used only with BG_HUD_LOCK_EN).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- video_on  in  1  active-video flag aligned with x/y.
- x  in  10  scan column.
- y  in  10  scan row.
- bg_x_offset  in  4  fine horizontal scroll, 0..15.
- bg_ram_rd_addr  out  16  tile RAM read address (registered).
- bg_ram_rd_data  in  32  tile RAM data, valid 1 clk after address.
- sheet_addr  out  14  sprite-sheet ROM address (registered).
- sheet_data  in  12  ROM RGB, valid 1 clk after address.
- pixel_rgb  out  12  output colour.
- pixel_opaque  out  1  1 = tile pixel drawn; 0 = background/transparent.
- de_out  out  1  video_on delayed to align with pixel_rgb.

Behaviour:
- Reset: all pipeline registers and all outputs go to 0 immediately (bg_ram_rd_addr=0, sheet_addr=0, pixel_rgb=0, pixel_opaque=0, de_out=0).
- Reset asserted mid-frame aborts all in-flight pixels; after release, valid output resumes 4 clocks after the first sampled input.
- Stage timing, for inputs sampled at rising edge E:
  - E: compute sx = x + bg_x_offset (11-bit); if sx >= H_ACTIVE, sx -= H_ACTIVE.
  - E: bg_ram_rd_addr <= (sx>>4) + (y>>4)*TILE_COLS.
  - E: carry px = sx[3:0], py = y[3:0], and v = video_on & x<H_ACTIVE & y<V_ACTIVE as sideband.
  - E+1: the external RAM registers its data.
  - E+2: decode bg_ram_rd_data and register sheet_addr plus sideband:
    - col = d[2:0], row = d[5:3], xflip = d[6], yflip = d[7], en = d[8]; bits 31:9 ignored.
    - px' = xflip ? 15-px : px; py' = yflip ? 15-py : py.
    - sheet_addr = {row, py', col, px'}, i.e. (row*16+py')*128 + col*16 + px'.
  - E+3: the external ROM registers its data.
  - E+4: pixel_opaque <= v & en & (sheet_data != KEY_COLOR); pixel_rgb <= pixel_opaque ? sheet_data : (v ? BG_COLOR : 0); de_out <= v.
- Latency: exactly 4 clocks, input sample to outputs; no stalls and no handshake.
- x >= H_ACTIVE or y >= V_ACTIVE: the RAM address is still computed (it may exceed 1199), but v=0, so the outputs are blanked.
- The wrap rule covers the maximum case: x=639 with offset 15 gives sx=14, tile col 0.
- Offset changes mid-line take effect on the pixel sampled at that edge; no synchronisation is provided.

Optional Feature:
- Macro: BG_HUD_LOCK_EN.
- Defined: when y < HUD_LINES the effective offset is 0, so score/HUD rows do not scroll.
- Undefined: bg_x_offset applies on every line; HUD_LINES is unused.

Decomposition:
- Shared package bg_pkg:
  - TILE_W=16, TILE_COLS=40, TILE_ROWS=30, SHEET_ADDR_W=14.
  - Attribute field positions: COL[2:0], ROW[5:3], XFLIP 6, YFLIP 7, ENABLE 8.
  - Attribute struct typedef, shared with game_engine writers.
- One sub-module, bg_attr_decode: combinational attribute unpack, flip and sheet-address formation, used at stage E+2.

Test Plan:
- Reset pulse mid-frame with video active -> all outputs 0 in the same cycle; after release, first de_out=1 appears exactly 4 clocks after video_on is sampled.
- Tile 0 attr 0x130, offset 0, y=0, x=5 -> bg_ram_rd_addr=0; sheet_addr=12293; ROM returns 12'h0A5 -> pixel_rgb=0x0A5, opaque=1 at E+4.
- Tile 0 attr 0x170 (xflip), x=5 -> sheet_addr=12298; attr 0x1B0 (yflip), y=0, x=5 -> sheet_addr=(96+15)*128+5=14213.
- Offset 15, x=630, y=40 -> sx=5, bg_ram_rd_addr=80. With BG_HUD_LOCK_EN, y=10 -> bg_ram_rd_addr=39; without it, y=10 -> bg_ram_rd_addr=0.
- Transparency and disable: attr with en=0 -> opaque=0, rgb=BG_COLOR; ROM returns KEY_COLOR with en=1 -> opaque=0, rgb=BG_COLOR.
- Blanking: video_on=0 or x=700 -> de_out=0, pixel_rgb=0, opaque=0 after 4 clocks, regardless of RAM/ROM contents.
